usb_data_buffer: RTL and testbench
==================================

# usb_data_buffer

Byte-wide 64-entry FIFO that bridges the AHB-Lite slave interface and the USB packet engines in the USB-AHB module. The AHB side pushes 1, 2 or 4 bytes per access from `tx_data` and pops 1, 2 or 4 bytes into `rx_data`. The USB side pushes received packet bytes and pops bytes for transmission, one byte per strobe. Occupancy is reported so the controller can schedule packets and flag errors.

## Interface
- `DEPTH`, 64, capacity in bytes; power of two, at most 64.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `n_rst` input 1: reset, synchronous and active-high (1 = reset). The name follows codebase convention; the polarity is as stated here.
- `clear` input 1: synchronous flush of the FIFO contents.
- `store_tx_data` input 1: AHB push strobe, single cycle.
- `tx_data` input 32: AHB write data; byte 0 is `[7:0]`.
- `data_size` input 2: bytes per AHB access. 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 4 bytes.
- `get_rx_data` input 1: AHB pop strobe, single cycle.
- `rx_data` output 32: AHB read data, registered.
- `store_rx_packet_data` input 1: USB push strobe, 1 byte.
- `rx_packet_data` input 8: byte pushed by the USB receiver.
- `get_tx_packet_data` input 1: USB pop strobe, 1 byte.
- `tx_packet_data` output 8: byte popped for the USB transmitter, registered.
- `buffer_occupancy` output 7: number of stored bytes, 0 to 64.

## Operation
- Storage: circular array of `DEPTH` bytes, with a 6-bit read pointer, a 6-bit write pointer and a 7-bit count. Both pointers wrap modulo `DEPTH`.
- Byte order is little-endian:
  - Push writes `tx_data[7:0]` first, then `[15:8]`, and so on.
  - Pop places the oldest byte in `rx_data[7:0]`.
- AHB pop:
  - Pops n = size(`data_size`) bytes.
  - Bytes beyond n in `rx_data` are 0.
  - If count < n, only `count` bytes are popped; the missing positions read 0 and count floors at 0.
- USB pop:
  - `tx_packet_data` takes the oldest byte.
  - If the FIFO is empty, `tx_packet_data` takes 0 and the pointers are unchanged.
- Push when full: bytes that do not fit are dropped silently, lowest-order bytes first kept. Pointers and count saturate at `DEPTH`.
- Source arbitration:
  - Both push strobes high: `store_tx_data` wins and the USB byte is dropped.
  - Both pop strobes high: `get_rx_data` wins and `tx_packet_data` holds.
- Push and pop in the same cycle:
  - The pop is evaluated first, against the pre-edge contents. pop_cnt = min(n_pop, count).
  - The push then uses space = `DEPTH` − count + pop_cnt.
  - New count = count − pop_cnt + push_cnt.
- `clear`:
  - Sets both pointers and count to 0; stored data becomes don't-care.
  - `rx_data` and `tx_packet_data` hold their values.
  - Overrides any push or pop in the same cycle.
- Reset, which has priority over everything else:
  - Pointers, count, `rx_data` and `tx_packet_data` become 0.
  - `buffer_occupancy` becomes 0.
  - Reset mid-operation discards all contents.

## Timing
- Every strobe is sampled on the rising edge of `clk`; the update is visible one cycle later.
- `rx_data` and `tx_packet_data` are valid the cycle after their pop strobe and hold until the next pop of the same type.
- `buffer_occupancy` is a direct register output reflecting the post-edge count. There is no combinational path from inputs to outputs.
- A strobe held high for k cycles performs k operations.
- There is no ready/valid handshake; the controller is responsible for checking `buffer_occupancy`.
- Throughput: one AHB access (up to 4 bytes) plus one USB byte per cycle.

## Test plan
- Reset: assert `n_rst` = 1 for 2 cycles with strobes active.
  - Required: `rx_data` = 0, `tx_packet_data` = 0 and `buffer_occupancy` = 0.
  - Required: after release with no strobes, all outputs hold 0.
- AHB word write then USB read-out: `store_tx_data` with `data_size` = 2 and `tx_data` = 0xDDCCBBAA.
  - Required: occupancy = 4.
  - Then 4× `get_tx_packet_data`: required `tx_packet_data` sequence 0xAA, 0xBB, 0xCC, 0xDD, ending with occupancy 0.
- USB write, AHB read with sizes:
  - Push bytes 0x01 through 0x07 via `store_rx_packet_data`.
  - `get_rx_data` with size 1: required `rx_data` = 0x00000201, occupancy 5.
  - Then size 2: required `rx_data` = 0x06050403, occupancy 1.
  - Then size 0: required `rx_data` = 0x00000007, occupancy 0.
- Full and wrap: push 64 bytes of 0x00 through 0x3F.
  - Required: occupancy = 64. A further push of 0xFF is dropped and occupancy stays 64.
  - Pop 2, push 0x40 and 0x41, then pop 64: required sequence 0x02 through 0x41.
- Underflow: with 1 byte 0x5A stored, `get_rx_data` with size 2.
  - Required: `rx_data` = 0x0000005A, occupancy = 0.
  - A following `get_tx_packet_data` gives 0x00 and occupancy stays 0.
- Simultaneous events: from 3 stored bytes, assert `store_tx_data` (size 1, 0xBEEF) and `get_tx_packet_data` together.
  - Required: the oldest byte is output and occupancy = 4.
  - Next, assert `clear` together with a push: required occupancy = 0.

Source files
------------

// File: rtl/usb_data_buffer.sv
// Byte-wide circular FIFO between the AHB slave (1/2/4-byte accesses) and the
// USB packet engines (1 byte per strobe), with registered read data and occupancy.
module usb_data_buffer #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        store_tx_data,
  input  logic [31:0] tx_data,
  input  logic [1:0]  data_size,
  input  logic        get_rx_data,
  output logic [31:0] rx_data,
  input  logic        store_rx_packet_data,
  input  logic [7:0]  rx_packet_data,
  input  logic        get_tx_packet_data,
  output logic [7:0]  tx_packet_data,
  output logic [6:0]  buffer_occupancy
);

  localparam logic [5:0] PTR_MASK = 6'(DEPTH - 1);
  localparam logic [6:0] DEPTH_C  = 7'(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [5:0]  r_rd_ptr;
  logic [5:0]  r_wr_ptr;
  logic [6:0]  r_count;
  logic [31:0] r_rx_data;
  logic [7:0]  r_tx_data;

  logic [2:0]  w_ahb_n;
  logic [2:0]  w_n_pop;
  logic [2:0]  w_pop_cnt;
  logic [2:0]  w_n_push;
  logic [2:0]  w_push_cnt;
  logic [6:0]  w_space;
  logic [31:0] w_push_bytes;
  logic [31:0] w_rx_next;
  logic [7:0]  w_tx_next;
  logic [5:0]  w_rd_idx [4];
  logic [5:0]  w_wr_idx [4];

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Pop is resolved first against pre-edge contents; freed space is then
  // available to a push in the same cycle.
  always_comb begin
    w_ahb_n   = size_bytes(data_size);
    w_n_pop   = get_rx_data ? w_ahb_n : (get_tx_packet_data ? 3'd1 : 3'd0);
    w_pop_cnt = ({4'b0, w_n_pop} > r_count) ? r_count[2:0] : w_n_pop;
    w_space   = DEPTH_C - r_count + {4'b0, w_pop_cnt};

    w_n_push     = store_tx_data ? w_ahb_n : (store_rx_packet_data ? 3'd1 : 3'd0);
    w_push_cnt   = ({4'b0, w_n_push} > w_space) ? w_space[2:0] : w_n_push;
    w_push_bytes = store_tx_data ? tx_data : {24'b0, rx_packet_data};
  end

  always_comb begin
    w_rx_next = 32'h0;
    for (int i = 0; i < 4; i++) begin
      w_rd_idx[i] = (r_rd_ptr + 6'(i)) & PTR_MASK;
      w_wr_idx[i] = (r_wr_ptr + 6'(i)) & PTR_MASK;
    end
    for (int i = 0; i < 4; i++) begin
      w_rx_next[8*i +: 8] = (3'(i) < w_pop_cnt) ? r_mem[w_rd_idx[i]] : 8'h00;
    end
    w_tx_next = (r_count != 7'd0) ? r_mem[r_rd_ptr] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_rd_ptr  <= 6'd0;
      r_wr_ptr  <= 6'd0;
      r_count   <= 7'd0;
      r_rx_data <= 32'h0;
      r_tx_data <= 8'h00;
    end else if (clear) begin
      r_rd_ptr <= 6'd0;
      r_wr_ptr <= 6'd0;
      r_count  <= 7'd0;
    end else begin
      r_rd_ptr <= (r_rd_ptr + {3'b0, w_pop_cnt}) & PTR_MASK;
      r_wr_ptr <= (r_wr_ptr + {3'b0, w_push_cnt}) & PTR_MASK;
      r_count  <= r_count - {4'b0, w_pop_cnt} + {4'b0, w_push_cnt};
      if (get_rx_data) begin
        r_rx_data <= w_rx_next;
      end else if (get_tx_packet_data) begin
        r_tx_data <= w_tx_next;
      end
    end
  end

  // Storage carries no reset; contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (!n_rst && !clear) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < w_push_cnt) begin
          r_mem[w_wr_idx[i]] <= w_push_bytes[8*i +: 8];
        end
      end
    end
  end

  assign rx_data          = r_rx_data;
  assign tx_packet_data   = r_tx_data;
  assign buffer_occupancy = r_count;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Scoreboard bench for usb_data_buffer: stimulus queues expected read data and
// occupancy, an independent monitor compares after every rising edge.
module tb_usb_data_buffer;

  logic        clk;
  logic        n_rst;
  logic        clear;
  logic        store_tx_data;
  logic [31:0] tx_data;
  logic [1:0]  data_size;
  logic        get_rx_data;
  logic [31:0] rx_data;
  logic        store_rx_packet_data;
  logic [7:0]  rx_packet_data;
  logic        get_tx_packet_data;
  logic [7:0]  tx_packet_data;
  logic [6:0]  buffer_occupancy;

  logic chk_occ;
  logic chk_hold;

  logic [31:0] q_rx  [$];
  logic [7:0]  q_tx  [$];
  logic [6:0]  q_occ [$];
  logic [31:0] last_rx;
  logic [7:0]  last_tx;

  int checks;
  int errors;

  usb_data_buffer #(.DEPTH(64)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .data_size            (data_size),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit clr,
                      input bit st_tx, input logic [31:0] txd, input logic [1:0] sz,
                      input bit grx, input logic [31:0] erx,
                      input bit st_rx, input logic [7:0] rxd,
                      input bit gtx, input logic [7:0] etx,
                      input int occ, input bit hold);
    @(negedge clk);
    n_rst                = rst;
    clear                = clr;
    store_tx_data        = st_tx;
    tx_data              = txd;
    data_size            = sz;
    get_rx_data          = grx;
    store_rx_packet_data = st_rx;
    rx_packet_data       = rxd;
    get_tx_packet_data   = gtx;
    chk_occ              = (occ >= 0);
    chk_hold             = hold;
    if (!rst && !clr) begin
      if (grx) q_rx.push_back(erx);
      else if (gtx) q_tx.push_back(etx);
    end
    if (occ >= 0) q_occ.push_back(7'(occ));
  endtask

  task automatic idle(input int occ, input bit hold);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, occ, hold);
  endtask
  task automatic push_usb(input logic [7:0] b, input int occ);
    step(0, 0, 0, 0, 0, 0, 0, 1, b, 0, 0, occ, 0);
  endtask
  task automatic push_ahb(input logic [31:0] d, input logic [1:0] sz, input int occ);
    step(0, 0, 1, d, sz, 0, 0, 0, 0, 0, 0, occ, 0);
  endtask
  task automatic pop_ahb(input logic [1:0] sz, input logic [31:0] erx, input int occ);
    step(0, 0, 0, 0, sz, 1, erx, 0, 0, 0, 0, occ, 0);
  endtask
  task automatic pop_usb(input logic [7:0] etx, input int occ);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, etx, occ, 0);
  endtask

  // Monitor: strobes are captured on the edge, outputs sampled 1 time unit later.
  initial begin
    bit c_rst, c_clr, c_grx, c_gtx, c_occ, c_hold;
    logic [31:0] e32;
    logic [7:0]  e8;
    logic [6:0]  e7;
    forever begin
      @(posedge clk);
      c_rst  = n_rst;
      c_clr  = clear;
      c_grx  = get_rx_data;
      c_gtx  = get_tx_packet_data;
      c_occ  = chk_occ;
      c_hold = chk_hold;
      #1;
      if (c_rst) begin
        chk("reset_rx_data", rx_data, 32'h0);
        chk("reset_tx_packet_data", {24'h0, tx_packet_data}, 32'h0);
        chk("reset_occupancy", {25'h0, buffer_occupancy}, 32'h0);
        last_rx = 32'h0;
        last_tx = 8'h00;
      end else begin
        if (!c_clr && c_grx) begin
          if (q_rx.size() == 0) chk("rx_queue_empty", 32'h1, 32'h0);
          else begin
            e32 = q_rx.pop_front();
            chk("rx_data", rx_data, e32);
            last_rx = e32;
          end
        end else if (!c_clr && c_gtx) begin
          if (q_tx.size() == 0) chk("tx_queue_empty", 32'h1, 32'h0);
          else begin
            e8 = q_tx.pop_front();
            chk("tx_packet_data", {24'h0, tx_packet_data}, {24'h0, e8});
            last_tx = e8;
          end
        end
        if (c_occ) begin
          if (q_occ.size() == 0) chk("occ_queue_empty", 32'h1, 32'h0);
          else begin
            e7 = q_occ.pop_front();
            chk("occupancy", {25'h0, buffer_occupancy}, {25'h0, e7});
          end
        end
      end
      if (c_hold) begin
        chk("hold_rx_data", rx_data, last_rx);
        chk("hold_tx_packet_data", {24'h0, tx_packet_data}, {24'h0, last_tx});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    last_rx = 32'h0;
    last_tx = 8'h00;
    n_rst = 1'b1; clear = 1'b0; store_tx_data = 1'b0; tx_data = 32'h0;
    data_size = 2'd0; get_rx_data = 1'b0; store_rx_packet_data = 1'b0;
    rx_packet_data = 8'h0; get_tx_packet_data = 1'b0; chk_occ = 1'b0; chk_hold = 1'b0;

    // Reset with every strobe active, then quiet cycles
    step(1, 0, 1, 32'h11223344, 2, 1, 0, 1, 8'h55, 1, 0, -1, 0);
    step(1, 0, 1, 32'h11223344, 2, 1, 0, 1, 8'h55, 1, 0, -1, 0);
    idle(0, 1);
    idle(0, 1);

    // AHB word in, USB bytes out
    push_ahb(32'hDDCCBBAA, 2, 4);
    pop_usb(8'hAA, 3);
    pop_usb(8'hBB, 2);
    pop_usb(8'hCC, 1);
    pop_usb(8'hDD, 0);

    // USB bytes in, AHB reads of each size
    for (int i = 1; i <= 7; i++) push_usb(8'(i), i);
    pop_ahb(1, 32'h00000201, 5);
    pop_ahb(2, 32'h06050403, 1);
    pop_ahb(0, 32'h00000007, 0);

    // Fill, overflow drop, wrap
    for (int i = 0; i < 64; i++) push_usb(8'(i), i + 1);
    push_usb(8'hFF, 64);
    pop_usb(8'h00, 63);
    pop_usb(8'h01, 62);
    push_usb(8'h40, 63);
    push_usb(8'h41, 64);
    for (int i = 0; i < 64; i++) pop_usb(8'(i + 2), 63 - i);

    // Underflow on both pop ports
    push_usb(8'h5A, 1);
    pop_ahb(1, 32'h0000005A, 0);
    pop_usb(8'h00, 0);

    // Simultaneous push/pop, then clear overriding push and pop
    push_usb(8'h10, 1);
    push_usb(8'h11, 2);
    push_usb(8'h12, 3);
    step(0, 0, 1, 32'h0000BEEF, 1, 0, 0, 0, 0, 1, 8'h10, 4, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 8'h33, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);

    // Arbitration: AHB wins both push and pop
    step(0, 0, 1, 32'h000000AB, 0, 0, 0, 1, 8'hCD, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 32'h000000AB, 0, 0, 1, 0, 0, 1);

    // Size 3 reads as 4 bytes, short fill
    push_usb(8'h77, 1);
    pop_ahb(3, 32'h00000077, 0);

    // Reset mid-operation discards contents
    push_usb(8'h99, 1);
    push_usb(8'h98, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    idle(0, 1);
    pop_usb(8'h00, 0);

    idle(-1, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", q_rx.size() + q_tx.size() + q_occ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
